// File: rtl/lfsr_pkg.sv
// Shared definitions for the 5-bit Fibonacci LFSR generator and its sequence checker.
package lfsr_pkg;

    localparam int unsigned LFSR_W = 5;
    localparam int unsigned TAP_A  = 4;
    localparam int unsigned TAP_B  = 2;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SYNC   = 2'd1,
        CHECK  = 2'd2,
        LOCKUP = 2'd3
    } state_e;

    // Successor of an LFSR word: shift left, feedback into bit 0.
    function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] word);
        return {word[LFSR_W-2:0], word[TAP_A] ^ word[TAP_B]};
    endfunction

endpackage

// File: rtl/lfsr_next_pred.sv
// Combinational successor predictor for a Fibonacci LFSR word.
module lfsr_next_pred #(
    parameter int unsigned W     = lfsr_pkg::LFSR_W,
    parameter int unsigned TAP_A = lfsr_pkg::TAP_A,
    parameter int unsigned TAP_B = lfsr_pkg::TAP_B
) (
    input  logic [W-1:0] din,
    output logic [W-1:0] pred
);

    always_comb begin
        pred = {din[W-2:0], din[TAP_A] ^ din[TAP_B]};
    end

endmodule

// File: rtl/lfsr_seq_checker.sv
// Monitors an LFSR stream: flags mismatches against the predicted successor,
// measures the sequence period and detects the all-zero lockup word.
module lfsr_seq_checker
    import lfsr_pkg::*;
#(
    parameter int unsigned W     = lfsr_pkg::LFSR_W,
    parameter int unsigned TAP_A = lfsr_pkg::TAP_A,
    parameter int unsigned TAP_B = lfsr_pkg::TAP_B,
    parameter int unsigned ERR_W = 8,
    parameter int unsigned PER_W = 6
) (
    input  logic             clk,
    input  logic             rset,
    input  logic [W-1:0]     din,
    input  logic             din_valid,
    input  logic             start,
    output logic             busy,
    output logic             error,
    output logic [ERR_W-1:0] err_count,
    output logic [PER_W-1:0] period,
    output logic             period_valid,
    output logic             lockup
);

    state_e             state_q, state_d;
    logic [W-1:0]       prev_q, prev_d;
    logic [W-1:0]       first_word_q, first_word_d;
    logic [PER_W-1:0]   cnt_q, cnt_d;
    logic [ERR_W-1:0]   err_count_q, err_count_d;
    logic [PER_W-1:0]   period_q, period_d;
    logic               busy_q, busy_d;
    logic               error_q, error_d;
    logic               period_valid_q, period_valid_d;
    logic               lockup_q, lockup_d;
    logic [W-1:0]       pred_c;
    logic [ERR_W-1:0]   err_inc_c;
    logic [PER_W-1:0]   cnt_inc_c;

    lfsr_next_pred #(
        .W     (W),
        .TAP_A (TAP_A),
        .TAP_B (TAP_B)
    ) u_pred (
        .din  (prev_q),
        .pred (pred_c)
    );

    assign err_inc_c = (err_count_q == '1) ? err_count_q : err_count_q + ERR_W'(1);
    assign cnt_inc_c = (cnt_q == '1) ? cnt_q : cnt_q + PER_W'(1);

    always_ff @(posedge clk) begin
        if (rset) begin
            state_q        <= IDLE;
            prev_q         <= '0;
            first_word_q   <= '0;
            cnt_q          <= '0;
            err_count_q    <= '0;
            period_q       <= '0;
            busy_q         <= 1'b0;
            error_q        <= 1'b0;
            period_valid_q <= 1'b0;
            lockup_q       <= 1'b0;
        end else begin
            state_q        <= state_d;
            prev_q         <= prev_d;
            first_word_q   <= first_word_d;
            cnt_q          <= cnt_d;
            err_count_q    <= err_count_d;
            period_q       <= period_d;
            busy_q         <= busy_d;
            error_q        <= error_d;
            period_valid_q <= period_valid_d;
            lockup_q       <= lockup_d;
        end
    end

    // start wins over a coincident sample, which is dropped.
    always_comb begin
        state_d        = state_q;
        prev_d         = prev_q;
        first_word_d   = first_word_q;
        cnt_d          = cnt_q;
        err_count_d    = err_count_q;
        period_d       = period_q;
        error_d        = 1'b0;
        period_valid_d = 1'b0;
        lockup_d       = lockup_q;

        if (start) begin
            state_d     = SYNC;
            err_count_d = '0;
            lockup_d    = 1'b0;
        end else if (din_valid) begin
            unique case (state_q)
                SYNC: begin
                    if (din != '0) begin
                        prev_d       = din;
                        first_word_d = din;
                        cnt_d        = PER_W'(1);
                        state_d      = CHECK;
                    end else begin
                        lockup_d = 1'b1;
                        state_d  = LOCKUP;
                    end
                end
                CHECK: begin
                    if (din == '0) begin
                        error_d     = 1'b1;
                        err_count_d = err_inc_c;
                        lockup_d    = 1'b1;
                        state_d     = LOCKUP;
                    end else if (din == pred_c) begin
                        prev_d = din;
                        if (din == first_word_q) begin
                            period_d       = cnt_q;
                            period_valid_d = 1'b1;
                            cnt_d          = PER_W'(1);
                        end else begin
                            cnt_d = cnt_inc_c;
                        end
                    end else begin
                        // Mismatch resyncs the period measurement on the new word.
                        error_d      = 1'b1;
                        err_count_d  = err_inc_c;
                        prev_d       = din;
                        first_word_d = din;
                        cnt_d        = PER_W'(1);
                    end
                end
                default: ;
            endcase
        end

        busy_d = (state_d == SYNC) || (state_d == CHECK);
    end

    assign busy         = busy_q;
    assign error        = error_q;
    assign err_count    = err_count_q;
    assign period       = period_q;
    assign period_valid = period_valid_q;
    assign lockup       = lockup_q;

endmodule

// File: tb/tb_lfsr_seq_checker.sv
// Directed self-checking bench for lfsr_seq_checker.
module tb_lfsr_seq_checker;

    logic       clk = 1'b0;
    logic       rset;
    logic [4:0] din;
    logic       din_valid;
    logic       start;
    logic       busy;
    logic       error;
    logic [7:0] err_count;
    logic [5:0] period;
    logic       period_valid;
    logic       lockup;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    lfsr_seq_checker dut (
        .clk          (clk),
        .rset         (rset),
        .din          (din),
        .din_valid    (din_valid),
        .start        (start),
        .busy         (busy),
        .error        (error),
        .err_count    (err_count),
        .period       (period),
        .period_valid (period_valid),
        .lockup       (lockup)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Apply one cycle of inputs, then sample just after the edge.
    task automatic step(input logic v, input logic [4:0] d, input logic s, input logic r);
        din_valid = v;
        din       = d;
        start     = s;
        rset      = r;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [4:0] nxt(input logic [4:0] x);
        return {x[3:0], x[4] ^ x[2]};
    endfunction

    logic [4:0] w;
    int         j;

    initial begin
        rset = 1'b1; din = '0; din_valid = 1'b0; start = 1'b0;

        // Reset values
        step(0, 5'd0, 0, 1);
        step(0, 5'd0, 0, 1);
        check_eq("rst_busy",   32'(busy), 0);
        check_eq("rst_error",  32'(error), 0);
        check_eq("rst_errcnt", 32'(err_count), 0);
        check_eq("rst_period", 32'(period), 0);
        check_eq("rst_pv",     32'(period_valid), 0);
        check_eq("rst_lockup", 32'(lockup), 0);

        // Clean run: period 31, pulses on samples 32 and 63
        step(0, 5'd0, 1, 0);
        check_eq("clean_busy_start", 32'(busy), 1);
        w = 5'b00001;
        for (int i = 1; i <= 70; i++) begin
            step(1, w, 0, 0);
            check_eq($sformatf("clean_pv_%0d", i), 32'(period_valid), (i == 32 || i == 63) ? 1 : 0);
            check_eq($sformatf("clean_err_%0d", i), 32'(error), 0);
            w = nxt(w);
        end
        check_eq("clean_period", 32'(period), 31);
        check_eq("clean_errcnt", 32'(err_count), 0);
        check_eq("clean_lockup", 32'(lockup), 0);
        check_eq("clean_busy",   32'(busy), 1);

        // Single fault on sample 10; stream continues from the faulty word
        step(0, 5'd0, 1, 0);
        w = 5'b00001;
        for (int i = 1; i <= 45; i++) begin
            if (i == 10) w = 5'b10101;
            step(1, w, 0, 0);
            check_eq($sformatf("fault_err_%0d", i), 32'(error), (i == 10) ? 1 : 0);
            check_eq($sformatf("fault_pv_%0d", i), 32'(period_valid), (i == 41) ? 1 : 0);
            w = nxt(w);
        end
        check_eq("fault_errcnt", 32'(err_count), 1);
        check_eq("fault_period", 32'(period), 31);

        // Lockup on all-zero word in CHECK
        step(0, 5'd0, 1, 0);
        step(1, 5'b00001, 0, 0);
        step(1, 5'b00010, 0, 0);
        step(1, 5'b00100, 0, 0);
        step(1, 5'b00000, 0, 0);
        check_eq("lock_err",    32'(error), 1);
        check_eq("lock_errcnt", 32'(err_count), 1);
        check_eq("lock_lockup", 32'(lockup), 1);
        check_eq("lock_busy",   32'(busy), 0);
        step(1, 5'b01001, 0, 0);
        check_eq("lock_hold_err",    32'(error), 0);
        check_eq("lock_hold_errcnt", 32'(err_count), 1);
        check_eq("lock_hold_lockup", 32'(lockup), 1);
        step(1, 5'b00000, 0, 0);
        check_eq("lock_hold2_err",  32'(error), 0);
        check_eq("lock_hold2_busy", 32'(busy), 0);
        step(0, 5'd0, 1, 0);
        check_eq("lock_restart_lockup", 32'(lockup), 0);
        check_eq("lock_restart_errcnt", 32'(err_count), 0);
        check_eq("lock_restart_busy",   32'(busy), 1);
        check_eq("lock_restart_period", 32'(period), 31);

        // Gapped valid: invalid cycles carry 0 and must be ignored
        w = 5'b00001;
        j = 0;
        for (int k = 0; k < 66; k++) begin
            if (k % 2 == 0) begin
                j++;
                step(1, w, 0, 0);
                w = nxt(w);
            end else begin
                step(0, 5'd0, 0, 0);
            end
            check_eq($sformatf("gap_pv_%0d", k), 32'(period_valid), (k % 2 == 0 && j == 32) ? 1 : 0);
            check_eq($sformatf("gap_err_%0d", k), 32'(error), 0);
        end
        check_eq("gap_period", 32'(period), 31);
        check_eq("gap_errcnt", 32'(err_count), 0);
        check_eq("gap_lockup", 32'(lockup), 0);

        // start with a coincident corrupt sample: sample dropped, SYNC entered
        step(1, 5'b10101, 1, 0);
        check_eq("start_mid_err",    32'(error), 0);
        check_eq("start_mid_busy",   32'(busy), 1);
        check_eq("start_mid_errcnt", 32'(err_count), 0);
        step(1, 5'b00001, 0, 0);
        check_eq("start_mid_sync_err", 32'(error), 0);
        step(1, 5'b00010, 0, 0);
        check_eq("start_mid_chk1_err", 32'(error), 0);
        step(1, 5'b00100, 0, 0);
        check_eq("start_mid_chk2_err", 32'(error), 0);

        // rset together with start
        step(1, 5'b10101, 1, 1);
        check_eq("rst_mid_busy",   32'(busy), 0);
        check_eq("rst_mid_error",  32'(error), 0);
        check_eq("rst_mid_errcnt", 32'(err_count), 0);
        check_eq("rst_mid_period", 32'(period), 0);
        check_eq("rst_mid_pv",     32'(period_valid), 0);
        check_eq("rst_mid_lockup", 32'(lockup), 0);
        step(1, 5'b00001, 0, 0);
        step(1, 5'b00011, 0, 0);
        check_eq("idle_busy",  32'(busy), 0);
        check_eq("idle_error", 32'(error), 0);

        // Error counter saturation
        step(0, 5'd0, 1, 0);
        step(1, 5'b00011, 0, 0);
        check_eq("sat_sync_err", 32'(error), 0);
        for (int i = 1; i <= 300; i++) begin
            step(1, 5'b00011, 0, 0);
            check_eq($sformatf("sat_err_%0d", i), 32'(error), 1);
            if (i == 1)   check_eq("sat_cnt_1",   32'(err_count), 1);
            if (i == 254) check_eq("sat_cnt_254", 32'(err_count), 254);
            if (i == 255) check_eq("sat_cnt_255", 32'(err_count), 255);
        end
        check_eq("sat_cnt_final", 32'(err_count), 255);
        check_eq("sat_pv",        32'(period_valid), 0);
        check_eq("sat_busy",      32'(busy), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/lfsr_seq_checker.md
Name: lfsr_seq_checker

Overview:
- Downstream consumer of the 5-bit Fibonacci LFSR (next = {x[3:0], x[4]^x[2]}, period 31).
- Samples the LFSR word each qualified cycle and checks it against the predicted successor of the previous sample.
- Counts mismatches, measures sequence period and flags the all-zero lockup state.
- Used as the built-in self-check next to the generator and as the bench reference monitor.

Parameters:
- W, 5, LFSR word width.
- TAP_A, 4, first feedback tap index.
- TAP_B, 2, second feedback tap index.
- ERR_W, 8, error counter width (saturating).
- PER_W, 6, period counter width (saturating).

Ports:
- clk  in  1  rising-edge clock.
- rset  in  1  synchronous active-high reset.
- din  in  W  LFSR word under test.
- din_valid  in  1  din qualified this cycle.
- start  in  1  one-cycle pulse; (re)arm the checker.
- busy  out  1  high in SYNC or CHECK.
- error  out  1  one-cycle pulse on mismatch.
- err_count  out  ERR_W  accumulated mismatches, saturates at all-ones.
- period  out  PER_W  last measured period.
- period_valid  out  1  one-cycle pulse when period updates.
- lockup  out  1  sticky; all-zero word seen.

Behaviour:
- Interface: one clock, clk; reset rset is synchronous and active-high. All outputs registered.
- Reset values: state=IDLE; busy, error, err_count, period, period_valid, lockup all 0; internal prev, first_word and cnt all 0.
- States: IDLE, SYNC, CHECK, LOCKUP. Samples with din_valid=0 are ignored in every state.
- IDLE: wait. start moves to SYNC, clears err_count and lockup.
- SYNC, valid din != 0: prev<=din, first_word<=din, cnt<=1, go to CHECK.
- SYNC, valid din == 0: lockup<=1, go to LOCKUP.
- CHECK, predicted word: pred = {prev[W-2:0], prev[TAP_A]^prev[TAP_B]}.
- CHECK, valid din == pred:
  - prev<=din.
  - If din == first_word: period<=cnt, period_valid pulse, cnt<=1.
  - Otherwise cnt<=cnt+1, saturating at all-ones.
- CHECK, valid din != pred, din != 0:
  - error pulse, err_count+1 (saturating).
  - Resync: prev<=din, first_word<=din, cnt<=1. No period_valid this cycle; mismatch has priority over period match.
- CHECK, valid din == 0: error pulse, err_count+1, lockup<=1, go to LOCKUP.
- LOCKUP: hold all outputs; leave only via start (to SYNC) or rset.
- Latency: error, period_valid and lockup appear one cycle after the sampling edge.
- start in any state: go to SYNC, clear err_count and lockup, keep period. start has priority over a coincident din_valid; that sample is discarded.
- rset mid-operation: immediate return to reset values on that edge; has priority over start.
- cnt saturation: cnt never wraps. If first_word does not recur, period is not updated.

Decomposition:
- Package lfsr_pkg:
  - LFSR_W=5, TAP_A=4, TAP_B=2 constants.
  - State enum {IDLE, SYNC, CHECK, LOCKUP}.
  - Function lfsr_next(word), shared with the generator.
- Sub-module lfsr_next_pred: combinational predictor, din W bits -> pred W bits. Instantiated once; reusable by generator-side assertions.
- FSM and counters stay in lfsr_seq_checker.

Test Plan:
- Clean run: rset, start, then the generator seeded 5'b00001 (00001, 00010, 00100, 01001, ...) with din_valid=1 continuously for 70 cycles -> period=31 with period_valid pulses on the 32nd and 63rd samples, err_count=0, lockup=0.
- Single fault: on sample 10 replace the correct word with 5'b10101 -> one error pulse, err_count=1, resync; next period_valid 31 samples after the fault, period=31.
- Lockup: in CHECK drive din=0 valid -> error pulse, err_count+1, lockup=1, busy=0; further valid words give no change; start -> SYNC, lockup=0, err_count=0.
- Gapped valid: clean sequence with din_valid toggling 1/0 every cycle -> invalid cycles ignored, period=31, err_count=0.
- Start/reset mid-run: start coincident with a valid corrupt word -> no error, SYNC entered, word discarded. rset together with start -> all outputs at reset values, state IDLE.
- Saturation: 300 consecutive mismatching nonzero words (alternating 00011/00011) -> err_count holds 255, error still pulses each sample.
